// File: rtl/drawbridge_ctrl_param.sv
// Purpose: parametrised drawbridge controller with N boat sensors, car occupancy count, travel watchdog, upright hold.
// Latency: Moore machine; inputs sampled at an edge take effect in State/MT/TFL/AL/CarCnt right after that edge.
// Backpressure: none; sensor and button inputs are levels or pulses and are never stalled.
//
// Ports:
//   Clk, Reset      rising-edge clock; synchronous active-low reset
//   CAIN, CAO       one-cycle pulses per car entering / leaving the bridge
//   MD              0 auto (boat sensors drive lift/lower), 1 manual (push button)
//   PB              manual push button level; only its rising edge acts
//   BS[N_BOAT]      boat sensors
//   H, L            bridge fully-up / fully-down limit sensors
//   MT              motor command: 00 off, 01 raise, 10 lower
//   AL              alarm (held in FAULT, one-cycle pulses on sensor errors)
//   TFL             traffic light: 0 go, 1 stop
//   State           0 FLAT, 1 LIFTING, 2 UPRIGHT, 3 LOWERING, 4 FAULT
//   CarCnt          cars currently on the bridge (saturating)
module drawbridge_ctrl_param #(
    parameter int CAR_W   = 4,
    parameter int N_BOAT  = 2,
    parameter int TIMEOUT = 16,
    parameter int HOLD    = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CAIN,
    input  logic              CAO,
    input  logic              MD,
    input  logic              PB,
    input  logic [N_BOAT-1:0] BS,
    input  logic              H,
    input  logic              L,
    output logic [1:0]        MT,
    output logic              AL,
    output logic              TFL,
    output logic [2:0]        State,
    output logic [CAR_W-1:0]  CarCnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [2:0] {
        S_FLAT  = 3'd0,
        S_LIFT  = 3'd1,
        S_UP    = 3'd2,
        S_LOWER = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t             state_q, state_nxt;
    logic               pb_q;
    logic               req_q, req_nxt;
    logic [TW-1:0]      timer_q, timer_nxt;
    logic [HW-1:0]      hold_q, hold_nxt;
    logic [CAR_W-1:0]   car_q, car_nxt;
    logic               car_err;
    logic               sensor_al;
    logic [1:0]         mt_nxt;
    logic               al_nxt;
    logic               tfl_nxt;

    logic               boat_any;
    logic               pbe;
    logic               timeout;
    logic               hold_done;
    logic               car_zero;
    logic               car_max;

    assign boat_any  = |BS;
    assign pbe       = PB & ~pb_q;
    // Compared with >= so a timer that kept counting while parked in a
    // tolerated-sensor condition still trips the watchdog afterwards.
    assign timeout   = (timer_q >= TW'(TIMEOUT - 1));
    assign hold_done = (hold_q >= HW'(HOLD - 1));
    assign car_zero  = (car_q == '0);
    assign car_max   = (&car_q);

    // ------------------------------------------------------------------
    // Car occupancy counter: simultaneous in/out cancels, saturates at
    // both ends, and an exit seen at zero is flagged as a sensor error.
    // ------------------------------------------------------------------
    always_comb begin
        car_nxt = car_q;
        car_err = 1'b0;
        if (CAIN && !CAO) begin
            if (!car_max) begin
                car_nxt = car_q + CAR_W'(1);
            end
        end else if (CAO && !CAIN) begin
            if (car_zero) begin
                car_err = 1'b1;
            end else begin
                car_nxt = car_q - CAR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State register (plus registered outputs and datapath state).
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_FLAT;
            pb_q    <= 1'b0;
            req_q   <= 1'b0;
            timer_q <= '0;
            hold_q  <= '0;
            car_q   <= '0;
            MT      <= 2'b00;
            AL      <= 1'b0;
            TFL     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pb_q    <= PB;
            req_q   <= req_nxt;
            timer_q <= timer_nxt;
            hold_q  <= hold_nxt;
            car_q   <= car_nxt;
            MT      <= mt_nxt;
            AL      <= al_nxt;
            TFL     <= tfl_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Within a state: fault conditions first, then
    // limit-switch completion, then boat reversal, then the watchdog.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        req_nxt   = req_q;
        hold_nxt  = hold_q;
        sensor_al = 1'b0;

        case (state_q)
            S_FLAT: begin
                if (req_q && car_zero && L) begin
                    state_nxt = S_LIFT;
                end else if (MD ? pbe : boat_any) begin
                    req_nxt = 1'b1;
                end
            end

            S_LIFT: begin
                if (H && L) begin
                    state_nxt = S_FAULT;
                end else if (H) begin
                    state_nxt = S_UP;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                end
            end

            S_UP: begin
                if (MD) begin
                    // Manual mode ignores boats; keep the hold count clean
                    // so a switch back to auto starts a fresh quiet period.
                    hold_nxt = '0;
                    if (pbe) begin
                        state_nxt = S_LOWER;
                    end
                end else if (boat_any) begin
                    hold_nxt = '0;
                end else if (hold_done) begin
                    state_nxt = S_LOWER;
                end else begin
                    hold_nxt = hold_q + HW'(1);
                end
            end

            S_LOWER: begin
                if (H && L) begin
                    state_nxt = S_FAULT;
                end else if (L) begin
                    state_nxt = S_FLAT;
                end else if (H) begin
                    // Fully-up while lowering is implausible; alarm but keep going.
                    sensor_al = 1'b1;
                end else if (!MD && boat_any) begin
                    state_nxt = S_LIFT;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                end
            end

            S_FAULT: begin
                state_nxt = S_FAULT;
            end

            default: begin
                state_nxt = S_FAULT;
            end
        endcase

        // A pending request is consumed when lifting starts, and a bridge
        // that has just come back down starts with no request outstanding.
        if (state_nxt != state_q) begin
            hold_nxt = '0;
            if (state_nxt == S_LIFT || state_nxt == S_FLAT) begin
                req_nxt = 1'b0;
            end
        end

        // Travel timer measures cycles spent in the current state.
        if (state_nxt != state_q) begin
            timer_nxt = '0;
        end else if (timer_q != '1) begin
            timer_nxt = timer_q + TW'(1);
        end else begin
            timer_nxt = timer_q;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: next-cycle values of the registered Moore outputs.
    // ------------------------------------------------------------------
    always_comb begin
        mt_nxt  = 2'b00;
        tfl_nxt = 1'b1;
        al_nxt  = 1'b0;

        case (state_nxt)
            S_LIFT:  mt_nxt = 2'b01;
            S_LOWER: mt_nxt = 2'b10;
            default: mt_nxt = 2'b00;
        endcase

        // In FLAT the light turns red as soon as a lift is requested so
        // cars stop entering while the occupants drain.
        if (state_nxt == S_FLAT) begin
            tfl_nxt = req_nxt;
        end

        al_nxt = (state_nxt == S_FAULT) || car_err || sensor_al;
    end

    assign State  = state_q;
    assign CarCnt = car_q;

endmodule

// File: tb/tb_drawbridge_ctrl_param.sv
// Purpose: directed self-checking bench for drawbridge_ctrl_param with default parameters.
// Latency: inputs are driven 1 time unit after a rising edge and outputs checked at the same point.
// Backpressure: not applicable.
module tb_drawbridge_ctrl_param;

    logic       Clk;
    logic       Reset;
    logic       CAIN;
    logic       CAO;
    logic       MD;
    logic       PB;
    logic [1:0] BS;
    logic       H;
    logic       L;
    logic [1:0] MT;
    logic       AL;
    logic       TFL;
    logic [2:0] State;
    logic [3:0] CarCnt;

    int tests;
    int fails;

    drawbridge_ctrl_param #(
        .CAR_W   (4),
        .N_BOAT  (2),
        .TIMEOUT (16),
        .HOLD    (4)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .CAIN   (CAIN),
        .CAO    (CAO),
        .MD     (MD),
        .PB     (PB),
        .BS     (BS),
        .H      (H),
        .L      (L),
        .MT     (MT),
        .AL     (AL),
        .TFL    (TFL),
        .State  (State),
        .CarCnt (CarCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        CAIN  = 1'b0;
        CAO   = 1'b0;
        MD    = 1'b0;
        PB    = 1'b0;
        BS    = 2'b00;
        H     = 1'b0;
        L     = 1'b1;
        tick();
        Reset = 1'b1;
    endtask

    // From FLAT with an empty bridge, auto mode: lift, reach top, lower.
    task automatic go_lowering();
        BS = 2'b01;
        tick();             // request latched
        tick();             // LIFTING
        BS = 2'b00;
        L  = 1'b0;
        H  = 1'b1;
        tick();             // UPRIGHT
        H  = 1'b0;
        repeat (4) tick();  // quiet hold period -> LOWERING
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // ---------------- reset ----------------
        do_reset();
        Reset = 1'b0;
        tick();
        chk("rst_state", 32'(State), 0);
        chk("rst_mt", 32'(MT), 0);
        chk("rst_tfl", 32'(TFL), 0);
        chk("rst_al", 32'(AL), 0);
        chk("rst_cnt", 32'(CarCnt), 0);
        Reset = 1'b1;

        // ---------------- auto full cycle ----------------
        CAIN = 1'b1; tick(); CAIN = 1'b0;
        chk("auto_cnt1", 32'(CarCnt), 1);
        CAO = 1'b1; tick(); CAO = 1'b0;
        chk("auto_cnt0", 32'(CarCnt), 0);
        BS = 2'b01; tick();
        chk("auto_req_tfl", 32'(TFL), 1);
        chk("auto_req_state", 32'(State), 0);
        tick();
        chk("auto_lift_state", 32'(State), 1);
        chk("auto_lift_mt", 32'(MT), 1);
        BS = 2'b00; H = 1'b1; L = 1'b0; tick();
        chk("auto_up_state", 32'(State), 2);
        chk("auto_up_mt", 32'(MT), 0);
        chk("auto_up_tfl", 32'(TFL), 1);
        H = 1'b0;
        repeat (3) tick();
        chk("auto_hold3", 32'(State), 2);
        tick();
        chk("auto_lower_state", 32'(State), 3);
        chk("auto_lower_mt", 32'(MT), 2);
        L = 1'b1; tick();
        chk("auto_flat_state", 32'(State), 0);
        chk("auto_flat_tfl", 32'(TFL), 0);
        chk("auto_flat_mt", 32'(MT), 0);

        // ---------------- occupied bridge ----------------
        do_reset();
        repeat (3) begin
            CAIN = 1'b1; tick(); CAIN = 1'b0; tick();
        end
        chk("occ_cnt3", 32'(CarCnt), 3);
        BS = 2'b10; tick(); tick();
        BS = 2'b00; tick();
        chk("occ_state", 32'(State), 0);
        chk("occ_tfl", 32'(TFL), 1);
        repeat (3) begin
            CAO = 1'b1; tick(); CAO = 1'b0;
        end
        chk("occ_cnt0", 32'(CarCnt), 0);
        chk("occ_still_flat", 32'(State), 0);
        tick();
        chk("occ_lift", 32'(State), 1);
        do_reset();
        chk("rst_mid_lift", 32'(State), 0);

        // ---------------- manual mode ----------------
        MD = 1'b1; BS = 2'b11;
        repeat (3) tick();
        chk("man_no_lift", 32'(State), 0);
        chk("man_no_tfl", 32'(TFL), 0);
        PB = 1'b1; tick();
        chk("man_pb_tfl", 32'(TFL), 1);
        tick();
        PB = 1'b0;
        chk("man_lift", 32'(State), 1);
        H = 1'b1; L = 1'b0; tick(); H = 1'b0;
        chk("man_up", 32'(State), 2);
        repeat (6) tick();
        chk("man_bs_ignored", 32'(State), 2);
        BS = 2'b00;
        repeat (6) tick();
        chk("man_no_hold_lower", 32'(State), 2);
        PB = 1'b1; tick(); PB = 1'b0;
        chk("man_lower", 32'(State), 3);
        chk("man_lower_mt", 32'(MT), 2);

        // ---------------- lift watchdog ----------------
        do_reset();
        BS = 2'b01; tick(); tick(); BS = 2'b00; L = 1'b0;
        chk("wd_lift", 32'(State), 1);
        repeat (15) tick();
        chk("wd_before", 32'(State), 1);
        tick();
        chk("wd_fault", 32'(State), 4);
        chk("wd_fault_mt", 32'(MT), 0);
        chk("wd_fault_al", 32'(AL), 1);
        chk("wd_fault_tfl", 32'(TFL), 1);
        H = 1'b1; MD = 1'b1; PB = 1'b1; BS = 2'b01;
        repeat (3) tick();
        chk("wd_absorb", 32'(State), 4);
        chk("wd_absorb_al", 32'(AL), 1);
        do_reset();
        chk("wd_rst_state", 32'(State), 0);
        chk("wd_rst_al", 32'(AL), 0);

        // ---------------- lowering sensor cases ----------------
        go_lowering();
        chk("lw_reach", 32'(State), 3);
        H = 1'b1; L = 1'b1; tick();
        chk("lw_hl_fault", 32'(State), 4);

        do_reset();
        go_lowering();
        H = 1'b1; L = 1'b0; tick(); H = 1'b0;
        chk("lw_h_al", 32'(AL), 1);
        chk("lw_h_state", 32'(State), 3);
        tick();
        chk("lw_h_al_clr", 32'(AL), 0);
        BS = 2'b01; tick(); BS = 2'b00;
        chk("lw_reverse", 32'(State), 1);
        chk("lw_reverse_mt", 32'(MT), 1);

        // ---------------- counter edges ----------------
        do_reset();
        CAIN = 1'b1; CAO = 1'b1; tick();
        chk("cnt_both0", 32'(CarCnt), 0);
        chk("cnt_both0_al", 32'(AL), 0);
        CAO = 1'b0;
        repeat (16) tick();
        CAIN = 1'b0;
        chk("cnt_sat", 32'(CarCnt), 15);
        CAIN = 1'b1; CAO = 1'b1; tick(); CAIN = 1'b0;
        chk("cnt_both15", 32'(CarCnt), 15);
        tick(); CAO = 1'b0;
        chk("cnt_dec", 32'(CarCnt), 14);
        do_reset();
        chk("cnt_rst", 32'(CarCnt), 0);
        CAO = 1'b1; tick(); CAO = 1'b0;
        chk("cnt_under_al", 32'(AL), 1);
        chk("cnt_under_val", 32'(CarCnt), 0);
        tick();
        chk("cnt_under_al_clr", 32'(AL), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/drawbridge_ctrl_param.md
Name: drawbridge_ctrl_param

Overview:
Parametrised drawbridge controller, the successor to the fixed 4-state DrawBridge FSM.
- Adds N boat-sensor channels and a saturating car-occupancy counter.
- Adds a motor-travel watchdog with a latched FAULT state, plus a minimum upright hold time.
- Keeps auto mode (boat-driven) and manual mode (push-button-driven).
- Sits between the bridge sensor/button inputs and the motor/traffic-light/alarm drivers.

Parameters:
CAR_W, 4, width of car occupancy counter (max 2^CAR_W-1 cars)
N_BOAT, 2, number of boat sensor channels
TIMEOUT, 16, max cycles allowed in LIFTING or LOWERING before FAULT (>=2)
HOLD, 4, consecutive cycles with all BS low required in UPRIGHT before auto lowering (>=1)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-low reset
CAIN  in  1  car entered bridge (1-cycle pulse per car)
CAO  in  1  car left bridge (1-cycle pulse per car)
MD  in  1  mode: 0 auto, 1 manual
PB  in  1  manual push button (level; rising edge acts)
BS  in  N_BOAT  boat sensors, one per channel
H  in  1  bridge-fully-up limit sensor
L  in  1  bridge-fully-down limit sensor
MT  out  2  motor: 00 off, 01 raise, 10 lower (11 never driven)
AL  out  1  alarm
TFL  out  1  traffic light: 0 go, 1 stop
State  out  3  0 FLAT, 1 LIFTING, 2 UPRIGHT, 3 LOWERING, 4 FAULT
CarCnt  out  CAR_W  current car occupancy

Behaviour:
- All outputs registered (Moore). A condition sampled at edge k takes effect in State/MT/TFL/AL after edge k.
- Reset (Reset==0 at an edge) is valid in any state, including mid-travel or FAULT:
  - State=FLAT, MT=00, AL=0, TFL=0, CarCnt=0.
  - Travel timer, hold counter, PB edge register and request flag all cleared.
- Car counter:
  - CAIN alone: +1. CAO alone: -1. Both in the same cycle: no change.
  - Saturates at all-ones: CAIN ignored at max.
  - CAO at 0 is ignored and pulses AL for 1 cycle (sensor error).
  - Counts in every state; counting does not gate State except in FLAT.
- PB edge: pbe = PB & ~PB_q, where PB_q is PB registered. Only pbe is used; a held PB acts once.
- Lift request (req):
  - MD=0: set when OR(BS)=1.
  - MD=1: set on pbe.
  - Cleared on entry to LIFTING.
- Mode changes never change State; they only select the request/lower source from the next cycle.
- FLAT:
  - MT=00.
  - TFL=0 while req=0. TFL=1 from the cycle after req is set.
  - Go to LIFTING when req=1 AND CarCnt==0 AND L=1.
  - While req=1 and CarCnt>0, remain in FLAT with TFL=1; cars may still exit.
- LIFTING:
  - MT=01, TFL=1. The travel timer counts cycles in this state.
  - H=1 and L=0 -> UPRIGHT.
  - H=1 and L=1 -> FAULT.
  - Timer reaches TIMEOUT with H=0 -> FAULT.
- UPRIGHT:
  - MT=00, TFL=1.
  - MD=0: hold counter counts consecutive cycles with OR(BS)=0 and resets to 0 when any BS=1. Reaching HOLD -> LOWERING.
  - MD=1: pbe -> LOWERING. BS is ignored.
- LOWERING:
  - MT=10, TFL=1. The travel timer restarts at 0 on entry.
  - L=1 and H=0 -> FLAT, with TFL=0 and req=0 from that cycle.
  - H=1 and L=0: AL pulses 1 cycle and the state stays LOWERING (implausible sensor, tolerated).
  - H=1 and L=1 -> FAULT.
  - MD=0 and OR(BS)=1 -> LIFTING (boat re-arrival reversal; timer restarts).
  - Timeout -> FAULT.
- FAULT: MT=00, TFL=1, AL=1. Absorbing; the only exit is Reset.
- Priority within a state: FAULT conditions > completion (H/L) > reversal > timeout counting.

Test Plan:
- Reset with L=1, all else 0 -> State=0, MT=00, TFL=0, AL=0, CarCnt=0.
- Auto full cycle:
  - Stimulus: CAIN pulse, then CAO pulse; BS=01; L=1.
  - Required: CarCnt goes 1 then 0; TFL=1; State 0->1 with MT=01.
  - Then H=1, L=0 -> State=2; BS=00 for 4 cycles -> State=3, MT=10; L=1 -> State=0, TFL=0.
- Occupied bridge:
  - Stimulus: 3 CAIN pulses, then BS=10.
  - Required: State stays 0 with TFL=1; after 3 CAO pulses, lift starts on the next cycle.
- Manual mode:
  - Stimulus: MD=1, BS=11 held.
  - Required: no lift. A 2-cycle PB pulse lifts once. In UPRIGHT, BS is ignored and a PB edge lowers.
- Faults:
  - LIFTING with H held 0 for 16 cycles -> State=4, MT=00, AL=1, held there until Reset=0.
  - H=L=1 in LOWERING -> State=4.
  - H=1 alone in LOWERING -> a 1-cycle AL pulse and State stays 3.
- Counter edges:
  - CAIN and CAO together -> no change.
  - 16 CAIN pulses -> CarCnt=15.
  - CAO at 0 -> 1-cycle AL pulse and CarCnt stays 0.
  - BS=01 during LOWERING in auto mode -> State=1.
